// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, LSB-first data, parity, stop bits on a baud strobe
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  baud_tick,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            parity_type,
    output logic                  tx_out,
    output logic                  busy_flag,
    output logic                  done_flag
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {IDLE, ARMED, START, DATA, PARITY, STOP} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [CW-1:0]           bit_cnt;
    logic                    stop_cnt;
    logic                    parity_bit;

    // Parity is resolved at acceptance so later changes on the inputs cannot leak into the frame.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic [1:0] pt);
        case (pt)
            2'b01:   calc_parity = ~(^d);
            2'b10:   calc_parity = ^d;
            default: calc_parity = 1'b1;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx_out     <= 1'b1;
            busy_flag  <= 1'b0;
            done_flag  <= 1'b0;
            shift_reg  <= '1;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b1;
        end else begin
            done_flag <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (send) begin
                        shift_reg  <= data_in;
                        parity_bit <= calc_parity(data_in, parity_type);
                        busy_flag  <= 1'b1;
                        state      <= ARMED;
                    end
                end
                ARMED: begin
                    if (baud_tick) begin
                        tx_out <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx_out    <= shift_reg[0];
                        shift_reg <= {1'b1, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx_out <= parity_bit;
                            state  <= PARITY;
                        end else begin
                            bit_cnt   <= bit_cnt + CW'(1);
                            tx_out    <= shift_reg[0];
                            shift_reg <= {1'b1, shift_reg[DATA_WIDTH-1:1]};
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        tx_out   <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            done_flag <= 1'b1;
                            busy_flag <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_out    <= 1'b1;
                    busy_flag <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
